alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single 8-bit ALU between two requesters, e.g. the core execute stage (port 0) and a secondary address/loop unit (port 1).
- Each requester presents an operation and two operands with a valid/ready handshake.
- The block grants requesters round-robin, latches the operands, drives the ALU for one cycle and registers the result and branch flag.
- It returns the response to the winner over a valid/ready response channel.

Parameters:
- DW, 8, operand/result width (must match the ALU).
- OPW, 4, alu_op width (encodings per the definitions package: SLB, ADD, SUB, SHIFTL, SHIFTR, BNZ, ALU_SLT, ALU_XOR, ALU_AND, ALU_OR).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  request valid, bit i = requester i.
- req_ready  output  2  request accepted this cycle, one-hot or zero.
- req_op0, req_op1  input  OPW  ALU operation of requester 0/1.
- req_a0, req_a1  input  DW  first operand (goes to ALU read1).
- req_b0, req_b1  input  DW  second operand (goes to ALU read0).
- resp_valid  output  2  response valid, one-hot or zero.
- resp_ready  input  2  response consumed by requester i.
- resp_result  output  DW  registered ALU result, shared by both requesters.
- resp_branch  output  1  registered ALU branch_result.
- alu_read1  output  DW  to ALU read1.
- alu_read0  output  DW  to ALU read0.
- alu_op  output  OPW  to ALU alu_op.
- alu_result  input  DW  from ALU result (combinational).
- alu_branch  input  1  from ALU branch_result.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (async assert, sync-to-clk deassert is the integrator's job). Values on reset:
  - state=IDLE, rr_ptr=0, grant=0.
  - Latched op/a/b = 0.
  - resp_result=0, resp_branch=0, req_ready=0, resp_valid=0, busy=0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - If no req_valid bit is set, stay in IDLE.
  - If exactly one bit is set, grant that requester.
  - If both are set, grant requester rr_ptr.
  - req_ready[grant] is asserted combinationally in this cycle only. The handshake completes in this cycle.
  - Latch op/a/b from the granted port and register grant. Next state is EXEC.
- EXEC (exactly 1 cycle):
  - alu_read1/alu_read0/alu_op = latched a/b/op.
  - At the edge, resp_result<=alu_result and resp_branch<=alu_branch. Next state is RESP.
- RESP:
  - resp_valid[grant]=1. resp_result and resp_branch are held stable.
  - When resp_ready[grant]=1, the response completes. Then rr_ptr<=~grant and the state returns to IDLE.
  - resp_ready of the non-granted port is ignored.
  - With resp_ready low, the block holds indefinitely. No timeout.
- Latency and throughput:
  - Accept in cycle N gives resp_valid in cycle N+2.
  - Minimum 3 cycles per operation. No new request is accepted until the response completes.
- ALU drive: alu_* outputs always reflect the latched registers. They are only meaningful during EXEC.
- Arithmetic: all widths are DW. The ALU wraps modulo 2^DW, and the arbiter adds no extension or saturation. The operand order is fixed: a to read1, b to read0.
- Fairness: rr_ptr changes only on response completion. A lone requester can be granted back-to-back regardless of rr_ptr.
- Requests are not latched while busy. A requester must hold req_valid and its fields stable until req_ready.
- req_valid dropping in IDLE before grant is legal; there is no side effect.
- Reset mid-operation (EXEC or RESP): everything returns to reset values and the pending response is discarded. No resp_valid is asserted after reset.
- Unknown or unused op encodings are passed through unchanged. The ALU returns 0 for them.

Test Plan:
1. Single ADD: after reset, port0 op=ADD a=0x3C b=0x05 -> req_ready=2'b01 in cycle N. resp_valid=2'b01 in N+2 with resp_result=0x41, resp_branch=0. busy is high N+1..completion.
2. Contention: both ports valid in the same cycle after reset (port0 SUB 0x02-0x05, port1 ALU_XOR 0xF0^0xFF) -> port0 is served first with result 0xFD (wrap). Then port1 is accepted in the next IDLE cycle with result 0x0F. Next double request grants port0 again.
3. Backpressure: port1 op=SHIFTL a=0x81 b=0x01, resp_ready low for 5 cycles -> resp_valid=2'b10 held, resp_result=0x02 stable. req_ready stays 0 despite port0 valid. Port0 is accepted the cycle after completion.
4. Branch: port0 op=BNZ a=0x00 -> resp_branch=0. Then a=0x07 -> resp_branch=1. Both responses complete at N+2 with resp_ready tied high. Back-to-back acceptance every 3 cycles.
5. Reset mid-op: assert rst_n low during EXEC of port1 ALU_AND 0xAA&0x0F -> outputs are zero immediately (async). After release, no resp_valid appears. A fresh double request grants port0 (rr_ptr=0).
6. Lone requester: port1 issues ALU_SLT 0x03<0x09 three times consecutively -> every request is granted, each result is 0x01, and 3-cycle spacing is held.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters; accept in N -> resp_valid in N+2.
// Accepts one request at a time and holds the registered response until the winner's resp_ready.
module alu_arbiter #(
  parameter int DW  = 8,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [OPW-1:0] req_op0,
  input  logic [OPW-1:0] req_op1,
  input  logic [DW-1:0]  req_a0,
  input  logic [DW-1:0]  req_a1,
  input  logic [DW-1:0]  req_b0,
  input  logic [DW-1:0]  req_b1,
  output logic [1:0]     resp_valid,
  input  logic [1:0]     resp_ready,
  output logic [DW-1:0]  resp_result,
  output logic           resp_branch,
  output logic [DW-1:0]  alu_read1,
  output logic [DW-1:0]  alu_read0,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_result,
  input  logic           alu_branch,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_rr_ptr;
  logic           r_grant;
  logic           w_grant_sel;
  logic           w_accept;
  logic           w_resp_done;
  logic [OPW-1:0] r_op;
  logic [DW-1:0]  r_a;
  logic [DW-1:0]  r_b;
  logic [DW-1:0]  r_result;
  logic           r_branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 2'b00;
    resp_valid  = 2'b00;
    w_accept    = 1'b0;
    w_resp_done = 1'b0;
    busy        = 1'b1;
    // A lone requester wins outright; rr_ptr only breaks ties.
    w_grant_sel = (req_valid == 2'b11) ? r_rr_ptr : req_valid[1];
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (|req_valid) begin
          w_accept    = 1'b1;
          req_ready   = w_grant_sel ? 2'b10 : 2'b01;
          w_state_nxt = EXEC;
        end
      end
      EXEC: w_state_nxt = RESP;
      RESP: begin
        resp_valid = r_grant ? 2'b10 : 2'b01;
        if (resp_ready[r_grant]) begin
          w_resp_done = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 1'b0;
      r_grant  <= 1'b0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_branch <= 1'b0;
    end else begin
      if (w_accept) begin
        r_grant <= w_grant_sel;
        r_op    <= w_grant_sel ? req_op1 : req_op0;
        r_a     <= w_grant_sel ? req_a1  : req_a0;
        r_b     <= w_grant_sel ? req_b1  : req_b0;
      end
      if (r_state == EXEC) begin
        r_result <= alu_result;
        r_branch <= alu_branch;
      end
      if (w_resp_done) r_rr_ptr <= ~r_grant;
    end
  end

  assign alu_read1   = r_a;
  assign alu_read0   = r_b;
  assign alu_op      = r_op;
  assign resp_result = r_result;
  assign resp_branch = r_branch;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: hand-computed vector table, reset-mid-op sequence, randomized run vs. transaction model.
module tb_alu_arbiter;

  localparam logic [3:0] SLB = 4'd0, ADD = 4'd1, SUB = 4'd2, SHL = 4'd3, SHR = 4'd4;
  localparam logic [3:0] BNZ = 4'd5, SLT = 4'd6, XOR = 4'd7, AND = 4'd8, OR = 4'd9;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [3:0] req_op0, req_op1, alu_op;
  logic [7:0] req_a0, req_a1, req_b0, req_b1;
  logic [7:0] resp_result, alu_read1, alu_read0, alu_result;
  logic       resp_branch, alu_branch, busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_arbiter #(.DW(8), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_branch(resp_branch),
    .alu_read1(alu_read1), .alu_read0(alu_read0), .alu_op(alu_op),
    .alu_result(alu_result), .alu_branch(alu_branch), .busy(busy)
  );

  // Reference ALU: {branch, result}; a is read1, b is read0; unknown ops give 0.
  function automatic logic [8:0] alu_ref(logic [3:0] op, logic [7:0] a, logic [7:0] b);
    logic [7:0] r;
    logic       br;
    r  = 8'h00;
    br = 1'b0;
    case (op)
      SLB: r = b;
      ADD: r = a + b;
      SUB: r = a - b;
      SHL: r = a << b;
      SHR: r = a >> b;
      BNZ: br = (a != 8'h00);
      SLT: r = (a < b) ? 8'h01 : 8'h00;
      XOR: r = a ^ b;
      AND: r = a & b;
      OR:  r = a | b;
      default: r = 8'h00;
    endcase
    return {br, r};
  endfunction

  always_comb {alu_branch, alu_result} = alu_ref(alu_op, alu_read1, alu_read0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [1:0] v;
    logic [3:0] op0;
    logic [7:0] a0, b0;
    logic [3:0] op1;
    logic [7:0] a1, b1;
    logic [1:0] rr;
    logic [1:0] e_rdy, e_rv;
    logic [7:0] e_res;
    logic       e_br, e_busy;
  } vec_t;

  function automatic vec_t mk(bit rst, logic [1:0] v, logic [3:0] op0, logic [7:0] a0, logic [7:0] b0,
                              logic [3:0] op1, logic [7:0] a1, logic [7:0] b1, logic [1:0] rr,
                              logic [1:0] e_rdy, logic [1:0] e_rv, logic [7:0] e_res,
                              logic e_br, logic e_busy);
    vec_t t;
    t.rst = rst; t.v = v; t.op0 = op0; t.a0 = a0; t.b0 = b0;
    t.op1 = op1; t.a1 = a1; t.b1 = b1; t.rr = rr;
    t.e_rdy = e_rdy; t.e_rv = e_rv; t.e_res = e_res; t.e_br = e_br; t.e_busy = e_busy;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(string tag, logic [1:0] rdy, logic [1:0] rv, logic [7:0] res,
                            logic br, logic bsy);
    chk($sformatf("%s.req_ready", tag), {30'd0, req_ready}, {30'd0, rdy});
    chk($sformatf("%s.resp_valid", tag), {30'd0, resp_valid}, {30'd0, rv});
    chk($sformatf("%s.resp_result", tag), {24'd0, resp_result}, {24'd0, res});
    chk($sformatf("%s.resp_branch", tag), {31'd0, resp_branch}, {31'd0, br});
    chk($sformatf("%s.busy", tag), {31'd0, busy}, {31'd0, bsy});
  endtask

  task automatic drive_idle();
    req_valid = 2'b00; resp_ready = 2'b00;
    req_op0 = 4'd0; req_a0 = 8'h00; req_b0 = 8'h00;
    req_op1 = 4'd0; req_a1 = 8'h00; req_b1 = 8'h00;
  endtask

  // Entered and left at posedge+1.
  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    #2;
    check_outs("reset", 2'b00, 2'b00, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic step(string tag, vec_t t);
    if (t.rst) do_reset();
    req_valid = t.v; resp_ready = t.rr;
    req_op0 = t.op0; req_a0 = t.a0; req_b0 = t.b0;
    req_op1 = t.op1; req_a1 = t.a1; req_b1 = t.b1;
    #4;
    check_outs(tag, t.e_rdy, t.e_rv, t.e_res, t.e_br, t.e_busy);
    @(posedge clk); #1;
  endtask

  vec_t tbl[$];

  // Randomized-run state
  int         m_phase, m_owner, m_rr, win;
  logic [7:0] m_res, m_nres;
  logic       m_br, m_nbr;
  bit         hold[2];
  logic [3:0] gop[2];
  logic [7:0] ga[2], gb[2];
  logic [1:0] e_rdy, e_rv, gv, grr;
  vec_t       rv;

  initial begin
    rst_n = 1'b1;
    drive_idle();
    #1;

    // Single ADD
    tbl.push_back(mk(1, 2'b01, ADD, 8'h3C, 8'h05, SLB, 8'h00, 8'h00, 2'b01, 2'b01, 2'b00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b00, ADD, 8'h3C, 8'h05, SLB, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00, 8'h00, 0, 1));
    tbl.push_back(mk(0, 2'b00, ADD, 8'h3C, 8'h05, SLB, 8'h00, 8'h00, 2'b01, 2'b00, 2'b01, 8'h41, 0, 1));
    tbl.push_back(mk(0, 2'b00, ADD, 8'h3C, 8'h05, SLB, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00, 8'h41, 0, 0));
    // Contention, wrap on SUB, round-robin back to port0
    tbl.push_back(mk(1, 2'b11, SUB, 8'h02, 8'h05, XOR, 8'hF0, 8'hFF, 2'b11, 2'b01, 2'b00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b10, SUB, 8'h02, 8'h05, XOR, 8'hF0, 8'hFF, 2'b11, 2'b00, 2'b00, 8'h00, 0, 1));
    tbl.push_back(mk(0, 2'b10, SUB, 8'h02, 8'h05, XOR, 8'hF0, 8'hFF, 2'b11, 2'b00, 2'b01, 8'hFD, 0, 1));
    tbl.push_back(mk(0, 2'b10, SUB, 8'h02, 8'h05, XOR, 8'hF0, 8'hFF, 2'b11, 2'b10, 2'b00, 8'hFD, 0, 0));
    tbl.push_back(mk(0, 2'b00, SUB, 8'h02, 8'h05, XOR, 8'hF0, 8'hFF, 2'b11, 2'b00, 2'b00, 8'hFD, 0, 1));
    tbl.push_back(mk(0, 2'b00, SUB, 8'h02, 8'h05, XOR, 8'hF0, 8'hFF, 2'b11, 2'b00, 2'b10, 8'h0F, 0, 1));
    tbl.push_back(mk(0, 2'b11, SUB, 8'h02, 8'h05, XOR, 8'hF0, 8'hFF, 2'b11, 2'b01, 2'b00, 8'h0F, 0, 0));
    tbl.push_back(mk(0, 2'b10, SUB, 8'h02, 8'h05, XOR, 8'hF0, 8'hFF, 2'b11, 2'b00, 2'b00, 8'h0F, 0, 1));
    tbl.push_back(mk(0, 2'b10, SUB, 8'h02, 8'h05, XOR, 8'hF0, 8'hFF, 2'b11, 2'b00, 2'b01, 8'hFD, 0, 1));
    tbl.push_back(mk(0, 2'b10, SUB, 8'h02, 8'h05, XOR, 8'hF0, 8'hFF, 2'b11, 2'b10, 2'b00, 8'hFD, 0, 0));
    tbl.push_back(mk(0, 2'b00, SUB, 8'h02, 8'h05, XOR, 8'hF0, 8'hFF, 2'b11, 2'b00, 2'b00, 8'hFD, 0, 1));
    tbl.push_back(mk(0, 2'b00, SUB, 8'h02, 8'h05, XOR, 8'hF0, 8'hFF, 2'b11, 2'b00, 2'b10, 8'h0F, 0, 1));
    // Backpressure on port1; port0 resp_ready must be ignored
    tbl.push_back(mk(0, 2'b10, ADD, 8'h3C, 8'h05, SHL, 8'h81, 8'h01, 2'b00, 2'b10, 2'b00, 8'h0F, 0, 0));
    tbl.push_back(mk(0, 2'b01, ADD, 8'h3C, 8'h05, SHL, 8'h81, 8'h01, 2'b00, 2'b00, 2'b00, 8'h0F, 0, 1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 2'b01, ADD, 8'h3C, 8'h05, SHL, 8'h81, 8'h01, 2'b01, 2'b00, 2'b10, 8'h02, 0, 1));
    tbl.push_back(mk(0, 2'b01, ADD, 8'h3C, 8'h05, SHL, 8'h81, 8'h01, 2'b10, 2'b00, 2'b10, 8'h02, 0, 1));
    tbl.push_back(mk(0, 2'b01, ADD, 8'h3C, 8'h05, SHL, 8'h81, 8'h01, 2'b00, 2'b01, 2'b00, 8'h02, 0, 0));
    tbl.push_back(mk(0, 2'b00, ADD, 8'h3C, 8'h05, SHL, 8'h81, 8'h01, 2'b01, 2'b00, 2'b00, 8'h02, 0, 1));
    tbl.push_back(mk(0, 2'b00, ADD, 8'h3C, 8'h05, SHL, 8'h81, 8'h01, 2'b01, 2'b00, 2'b01, 8'h41, 0, 1));
    // BNZ back-to-back, resp_ready tied high
    tbl.push_back(mk(0, 2'b01, BNZ, 8'h00, 8'h00, SLB, 8'h00, 8'h00, 2'b11, 2'b01, 2'b00, 8'h41, 0, 0));
    tbl.push_back(mk(0, 2'b01, BNZ, 8'h07, 8'h00, SLB, 8'h00, 8'h00, 2'b11, 2'b00, 2'b00, 8'h41, 0, 1));
    tbl.push_back(mk(0, 2'b01, BNZ, 8'h07, 8'h00, SLB, 8'h00, 8'h00, 2'b11, 2'b00, 2'b01, 8'h00, 0, 1));
    tbl.push_back(mk(0, 2'b01, BNZ, 8'h07, 8'h00, SLB, 8'h00, 8'h00, 2'b11, 2'b01, 2'b00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b00, BNZ, 8'h07, 8'h00, SLB, 8'h00, 8'h00, 2'b11, 2'b00, 2'b00, 8'h00, 0, 1));
    tbl.push_back(mk(0, 2'b00, BNZ, 8'h07, 8'h00, SLB, 8'h00, 8'h00, 2'b11, 2'b00, 2'b01, 8'h00, 1, 1));
    // Lone requester port1 granted three times in a row
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(0, 2'b10, SLB, 8'h00, 8'h00, SLT, 8'h03, 8'h09, 2'b10, 2'b10, 2'b00,
                       (k == 0) ? 8'h00 : 8'h01, (k == 0) ? 1'b1 : 1'b0, 0));
      tbl.push_back(mk(0, (k == 2) ? 2'b00 : 2'b10, SLB, 8'h00, 8'h00, SLT, 8'h03, 8'h09, 2'b10, 2'b00, 2'b00,
                       (k == 0) ? 8'h00 : 8'h01, (k == 0) ? 1'b1 : 1'b0, 1));
      tbl.push_back(mk(0, (k == 2) ? 2'b00 : 2'b10, SLB, 8'h00, 8'h00, SLT, 8'h03, 8'h09, 2'b10, 2'b00, 2'b10,
                       8'h01, 0, 1));
    end

    for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i]);

    // Reset during EXEC of port1; rr_ptr is first moved to 1 by a port0 completion
    step("rst_a", mk(0, 2'b01, ADD, 8'h3C, 8'h05, SLB, 8'h00, 8'h00, 2'b01, 2'b01, 2'b00, 8'h01, 0, 0));
    step("rst_b", mk(0, 2'b00, ADD, 8'h3C, 8'h05, SLB, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00, 8'h01, 0, 1));
    step("rst_c", mk(0, 2'b00, ADD, 8'h3C, 8'h05, SLB, 8'h00, 8'h00, 2'b01, 2'b00, 2'b01, 8'h41, 0, 1));
    step("rst_d", mk(0, 2'b10, SLB, 8'h00, 8'h00, AND, 8'hAA, 8'h0F, 2'b11, 2'b10, 2'b00, 8'h41, 0, 0));
    req_valid = 2'b00; resp_ready = 2'b11;
    #2;
    chk("rst_exec.alu_op", {28'd0, alu_op}, {28'd0, AND});
    rst_n = 1'b0;
    #1;
    check_outs("rst_async", 2'b00, 2'b00, 8'h00, 1'b0, 1'b0);
    chk("rst_async.alu_read1", {24'd0, alu_read1}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      step($sformatf("rst_quiet%0d", i), mk(0, 2'b00, SLB, 8'h00, 8'h00, SLB, 8'h00, 8'h00, 2'b11,
                                            2'b00, 2'b00, 8'h00, 0, 0));
    step("rst_rr", mk(0, 2'b11, SUB, 8'h02, 8'h05, XOR, 8'hF0, 8'hFF, 2'b11, 2'b01, 2'b00, 8'h00, 0, 0));

    // Randomized traffic against a transaction-level model
    do_reset();
    m_phase = 0; m_owner = 0; m_rr = 0; m_res = 8'h00; m_br = 1'b0; m_nres = 8'h00; m_nbr = 1'b0;
    hold[0] = 0; hold[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!hold[p] && $urandom_range(0, 2) != 0) begin
          hold[p] = 1;
          gop[p]  = 4'($urandom_range(0, 11));
          ga[p]   = 8'($urandom);
          gb[p]   = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
        end
      end
      gv  = {hold[1], hold[0]};
      grr = 2'($urandom);
      e_rdy = 2'b00;
      win   = 0;
      if (m_phase == 0 && gv != 2'b00) begin
        win   = (gv == 2'b11) ? m_rr : ((gv == 2'b10) ? 1 : 0);
        e_rdy = 2'(2'b01 << win);
      end
      e_rv = (m_phase == 2) ? 2'(2'b01 << m_owner) : 2'b00;
      rv = mk(0, gv, gop[0], ga[0], gb[0], gop[1], ga[1], gb[1], grr,
              e_rdy, e_rv, m_res, m_br, (m_phase != 0));
      step($sformatf("rnd%0d", c), rv);
      case (m_phase)
        0: if (e_rdy != 2'b00) begin
             m_owner = win;
             {m_nbr, m_nres} = alu_ref(gop[win], ga[win], gb[win]);
             hold[win] = 0;
             m_phase = 1;
           end
        1: begin
             m_res = m_nres; m_br = m_nbr; m_phase = 2;
           end
        default: if (grr[m_owner]) begin
             m_rr = 1 - m_owner;
             m_phase = 0;
           end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
